// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the memory-mapped peripheral block: register
// addresses, TCON bit positions and timer reset defaults.
package peripheral_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

    localparam int TCON_EN = 0;  // timer enable
    localparam int TCON_IE = 1;  // interrupt enable
    localparam int TCON_IP = 2;  // interrupt pending

    localparam logic [31:0] DEF_TIMER_TH = 32'hFFFF_F000;
    localparam logic [31:0] DEF_TIMER_TL = 32'hFFFF_F000;

    // Byte address to word address; the low two bits never select a register.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// CPU-side data bus into the peripheral block.
interface peripheral_bus_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/peripheral_bus_timer.sv
// Reloading 32-bit timer: TH reload, TL count, TCON control and the
// interrupt request derived from TCON.
import peripheral_pkg::*;

module periph_timer #(
    parameter logic [31:0] TIMER_RESET_TH = DEF_TIMER_TH,
    parameter logic [31:0] TIMER_RESET_TL = DEF_TIMER_TL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we_i,
    input  logic        tl_we_i,
    input  logic        tcon_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        ovf, ovf_set;

    // Next state: CPU writes to TL override counting; reload always uses the
    // TH held this cycle; a pending interrupt raised alongside a TCON write
    // is OR-ed in so it cannot be lost.
    always_comb begin
        ovf     = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
        ovf_set = ovf && tcon_q[TCON_IE];

        th_d = th_we_i ? wdata_i : th_q;

        tl_d = tl_q;
        if (tl_we_i)              tl_d = wdata_i;
        else if (tcon_q[TCON_EN]) tl_d = ovf ? th_q : tl_q + 32'd1;

        tcon_d = tcon_q;
        if (tcon_we_i) tcon_d = wdata_i[2:0];
        tcon_d[TCON_IP] = tcon_d[TCON_IP] | ovf_set;
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= TIMER_RESET_TH;
            tl_q   <= TIMER_RESET_TL;
            tcon_q <= 3'b000;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IE] & tcon_q[TCON_IP];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral slave: timer, LED, switch, 7-segment and,
// with PERIPH_SYSTICK_EN defined, a free-running SYSTICK counter.
import peripheral_pkg::*;

module peripheral_bus #(
    parameter logic [31:0] TIMER_RESET_TH = DEF_TIMER_TH,
    parameter logic [31:0] TIMER_RESET_TL = DEF_TIMER_TL
) (
    input  logic             clk,
    input  logic             reset,
    peripheral_bus_if.slave  bus,
    output logic [7:0]       led,
    input  logic [7:0]       switch,
    output logic [11:0]      digi,
    output logic             irqout
);

    logic [31:0] waddr;
    logic        th_we, tl_we, tcon_we, led_we, digi_we;
    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [7:0]  led_q, led_d, sw_q;
    logic [11:0] digi_q, digi_d;

    assign waddr = word_addr(bus.addr);

    // Write decode; SWITCH and SYSTICK are read-only and never decoded here.
    always_comb begin
        th_we   = bus.wr && (waddr == ADDR_TH);
        tl_we   = bus.wr && (waddr == ADDR_TL);
        tcon_we = bus.wr && (waddr == ADDR_TCON);
        led_we  = bus.wr && (waddr == ADDR_LED);
        digi_we = bus.wr && (waddr == ADDR_DIGI);
        led_d   = led_we  ? bus.wdata[7:0]  : led_q;
        digi_d  = digi_we ? bus.wdata[11:0] : digi_q;
    end

    periph_timer #(
        .TIMER_RESET_TH (TIMER_RESET_TH),
        .TIMER_RESET_TL (TIMER_RESET_TL)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .th_we_i   (th_we),
        .tl_we_i   (tl_we),
        .tcon_we_i (tcon_we),
        .wdata_i   (bus.wdata),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (irqout)
    );

    // LED/DIGI registers and the single-stage switch sampler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q  <= 8'h00;
            digi_q <= 12'h000;
            sw_q   <= 8'h00;
        end else begin
            led_q  <= led_d;
            digi_q <= digi_d;
            sw_q   <= switch;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q;

    // Free-running tick counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) systick_q <= 32'h0;
        else        systick_q <= systick_q + 32'd1;
    end
`endif

    // Zero-latency read mux for the single-cycle datapath.
    always_comb begin
        bus.rdata = 32'h0;
        if (bus.rd) begin
            case (waddr)
                ADDR_TH:      bus.rdata = th;
                ADDR_TL:      bus.rdata = tl;
                ADDR_TCON:    bus.rdata = {29'h0, tcon};
                ADDR_LED:     bus.rdata = {24'h0, led_q};
                ADDR_SWITCH:  bus.rdata = {24'h0, sw_q};
                ADDR_DIGI:    bus.rdata = {20'h0, digi_q};
`ifdef PERIPH_SYSTICK_EN
                ADDR_SYSTICK: bus.rdata = systick_q;
`endif
                default:      bus.rdata = 32'h0;
            endcase
        end
    end

    assign led  = led_q;
    assign digi = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus; SYSTICK steps only with PERIPH_SYSTICK_EN.
module tb_peripheral_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  led;
    logic [7:0]  switch;
    logic [11:0] digi;
    logic        irqout;
    int          checks = 0;
    int          errors = 0;

    peripheral_bus_if bus_if ();

    peripheral_bus dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .led    (led),
        .switch (switch),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; takes effect at the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.wr    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        step();
        bus_if.wr    = 1'b0;
    endtask

    // Combinational read within the current cycle (no time advance past the edge).
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus_if.rd   = 1'b1;
        bus_if.addr = a;
        #1;
        chk(tag, bus_if.rdata, exp);
        bus_if.rd   = 1'b0;
    endtask

    initial begin
        logic [31:0] t0;
        reset        = 1'b0;
        bus_if.rd    = 1'b0;
        bus_if.wr    = 1'b0;
        bus_if.addr  = 32'h0;
        bus_if.wdata = 32'h0;
        switch       = 8'h00;
        t0           = 32'h0;

        // Reset state
        #12;
        chk("rst_irq", {31'h0, irqout}, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_digi", {20'h0, digi}, 32'h0);
        rd_chk("rst_tcon", 32'h4000_0008, 32'h0);
        rd_chk("rst_tl", 32'h4000_0004, 32'hFFFF_F000);
        rd_chk("rst_th", 32'h4000_0000, 32'hFFFF_F000);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Overflow and reload
        wr(32'h4000_0000, 32'hFFFF_FFFC);
        wr(32'h4000_0004, 32'hFFFF_FFFE);
        wr(32'h4000_0008, 32'h0000_0003);
        rd_chk("tl_start", 32'h4000_0004, 32'hFFFF_FFFE);
        step();
        rd_chk("tl_ffff", 32'h4000_0004, 32'hFFFF_FFFF);
        chk("irq_pre", {31'h0, irqout}, 32'h0);
        step();
        rd_chk("tl_reload", 32'h4000_0004, 32'hFFFF_FFFC);
        rd_chk("tcon_pend", 32'h4000_0008, 32'h7);
        chk("irq_set", {31'h0, irqout}, 32'h1);

        // Clear pending, next overflow re-raises it
        wr(32'h4000_0008, 32'h0000_0003);
        chk("irq_clr", {31'h0, irqout}, 32'h0);
        rd_chk("tl_fffd", 32'h4000_0004, 32'hFFFF_FFFD);
        step();
        step();
        chk("irq_still0", {31'h0, irqout}, 32'h0);
        step();
        chk("irq_again", {31'h0, irqout}, 32'h1);
        rd_chk("tl_reload2", 32'h4000_0004, 32'hFFFF_FFFC);

        // TCON write in the overflow cycle keeps the pending bit
        wr(32'h4000_0008, 32'h0000_0003);
        step();
        step();
        rd_chk("tl_ovf_cyc", 32'h4000_0004, 32'hFFFF_FFFF);
        wr(32'h4000_0008, 32'h0000_0003);
        rd_chk("tcon_race", 32'h4000_0008, 32'h7);
        chk("irq_race", {31'h0, irqout}, 32'h1);

        // TH write in the reload cycle: reload uses the old TH
        wr(32'h4000_0008, 32'h0000_0003);
        step();
        step();
        wr(32'h4000_0000, 32'hFFFF_FFF0);
        rd_chk("th_race_tl", 32'h4000_0004, 32'hFFFF_FFFC);
        rd_chk("th_race_th", 32'h4000_0000, 32'hFFFF_FFF0);

        // Disable: TL holds
        wr(32'h4000_0008, 32'h0000_0000);
        chk("irq_off", {31'h0, irqout}, 32'h0);
        rd_chk("tl_stop", 32'h4000_0004, 32'hFFFF_FFFD);
        step();
        rd_chk("tl_hold", 32'h4000_0004, 32'hFFFF_FFFD);

        // TL write beats increment; overflow with IE=0 sets no pending
        wr(32'h4000_0008, 32'h0000_0001);
        wr(32'h4000_0004, 32'h0000_0010);
        rd_chk("tl_wr_wins", 32'h4000_0004, 32'h0000_0010);
        step();
        rd_chk("tl_inc", 32'h4000_0004, 32'h0000_0011);
        wr(32'h4000_0004, 32'hFFFF_FFFF);
        step();
        rd_chk("tl_reload_noie", 32'h4000_0004, 32'hFFFF_FFF0);
        rd_chk("tcon_noie", 32'h4000_0008, 32'h1);
        chk("irq_noie", {31'h0, irqout}, 32'h0);
        wr(32'h4000_0008, 32'h0000_0000);

        // Switch / LED / DIGI
        switch = 8'hA5;
        rd_chk("sw_before", 32'h4000_0010, 32'h00);
        step();
        rd_chk("sw_after", 32'h4000_0010, 32'hA5);
        wr(32'h4000_000C, 32'h0000_003C);
        wr(32'h4000_0014, 32'h0000_0E7F);
        chk("led_pin", {24'h0, led}, 32'h3C);
        chk("digi_pin", {20'h0, digi}, 32'hE7F);
        rd_chk("led_rd", 32'h4000_000C, 32'h3C);
        rd_chk("digi_rd", 32'h4000_0014, 32'hE7F);
        rd_chk("led_lowbits", 32'h4000_000F, 32'h3C);
        wr(32'h4000_0010, 32'h0000_00FF);
        rd_chk("sw_ro", 32'h4000_0010, 32'hA5);
        wr(32'h4000_0020, 32'h0000_00FF);
        chk("unmapped_wr_led", {24'h0, led}, 32'h3C);

        // Unmapped and rd=0
        rd_chk("unmapped", 32'h4000_0020, 32'h0);
        bus_if.addr = 32'h4000_000C;
        #1;
        chk("rd_low", bus_if.rdata, 32'h0);
`ifdef PERIPH_SYSTICK_EN
        bus_if.rd   = 1'b1;
        bus_if.addr = 32'h4000_0018;
        #1;
        t0 = bus_if.rdata;
        bus_if.rd = 1'b0;
        repeat (10) step();
        rd_chk("systick_delta", 32'h4000_0018, t0 + 32'd10);
`else
        rd_chk("systick_off", 32'h4000_0018, 32'h0);
`endif

        // Asynchronous reset mid-count
        wr(32'h4000_0008, 32'h0000_0003);
        step();
        #2;
        reset = 1'b0;
        #1;
        rd_chk("arst_tl", 32'h4000_0004, 32'hFFFF_F000);
        rd_chk("arst_tcon", 32'h4000_0008, 32'h0);
        chk("arst_led", {24'h0, led}, 32'h0);
        chk("arst_irq", {31'h0, irqout}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
